// File: rtl/draw_arbiter.sv
// Round-robin sprite-draw arbiter: four requesters share one VGA write port, each burst plots a SPRITE_W x SPRITE_H block.
// Optional macro DRAW_ARBITER_CLIP_EN suppresses plots that fall outside the 160x120 screen.
module draw_arbiter #(
    parameter int SPRITE_W = 4,
    parameter int SPRITE_H = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [31:0] x_in,
    input  logic [27:0] y_in,
    input  logic [11:0] colour_in,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

`ifdef DRAW_ARBITER_CLIP_EN
    localparam int XS = 9;
    localparam int YS = 8;
`else
    localparam int XS = 8;
    localparam int YS = 7;
`endif
    localparam logic [2:0] LAST_X = 3'(SPRITE_W - 1);
    localparam logic [2:0] LAST_Y = 3'(SPRITE_H - 1);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  bx_q, bx_d;
    logic [6:0]  by_q, by_d;
    logic [2:0]  bc_q, bc_d;
    logic [2:0]  dx_q, dx_d, dy_q, dy_d;
    logic [3:0]  grant_q, grant_d, done_q, done_d;
    logic [7:0]  vx_q, vx_d;
    logic [6:0]  vy_q, vy_d;
    logic [2:0]  vc_q, vc_d;
    logic        plot_q, plot_d;

    logic [1:0]  sel, idx;
    logic        hit;
    logic [7:0]  base_x;
    logic [6:0]  base_y;
    logic [2:0]  base_c;
    logic [2:0]  nx_dx, nx_dy;
    logic [XS-1:0] sum_x;
    logic [YS-1:0] sum_y;
    logic        in_range, last_px;

    // First pending requester at or after the rotating pointer.
    always_comb begin
        sel = ptr_q;
        hit = 1'b0;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
        end
    end

    // The pixel being prepared: pixel 0 of a new burst in IDLE, the next pixel in DRAW.
    always_comb begin
        base_x  = (state_q == IDLE) ? x_in[8*sel +: 8]      : bx_q;
        base_y  = (state_q == IDLE) ? y_in[7*sel +: 7]      : by_q;
        base_c  = (state_q == IDLE) ? colour_in[3*sel +: 3] : bc_q;
        last_px = (dx_q == LAST_X) && (dy_q == LAST_Y);
        nx_dx   = 3'd0;
        nx_dy   = 3'd0;
        if (state_q == DRAW) begin
            nx_dx = (dx_q == LAST_X) ? 3'd0 : dx_q + 3'd1;
            nx_dy = (dx_q == LAST_X) ? dy_q + 3'd1 : dy_q;
        end
        sum_x = XS'(base_x) + XS'(nx_dx);
        sum_y = YS'(base_y) + YS'(nx_dy);
`ifdef DRAW_ARBITER_CLIP_EN
        in_range = (sum_x <= XS'(159)) && (sum_y <= YS'(119));
`else
        in_range = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bc_d    = bc_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        grant_d = grant_q;
        done_d  = 4'd0;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;
        plot_d  = 1'b0;
        case (state_q)
            IDLE: if (hit) begin
                state_d = DRAW;
                grant_d = 4'b0001 << sel;
                ptr_d   = sel + 2'd1;
                bx_d    = base_x;
                by_d    = base_y;
                bc_d    = base_c;
                dx_d    = 3'd0;
                dy_d    = 3'd0;
                vx_d    = sum_x[7:0];
                vy_d    = sum_y[6:0];
                vc_d    = base_c;
                plot_d  = in_range;
            end
            DRAW: if (last_px) begin
                state_d = DONE;
                grant_d = 4'd0;
                done_d  = grant_q;
            end else begin
                dx_d   = nx_dx;
                dy_d   = nx_dy;
                vx_d   = sum_x[7:0];
                vy_d   = sum_y[6:0];
                plot_d = in_range;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            bx_q    <= 8'd0;
            by_q    <= 7'd0;
            bc_q    <= 3'd0;
            dx_q    <= 3'd0;
            dy_q    <= 3'd0;
            grant_q <= 4'd0;
            done_q  <= 4'd0;
            vx_q    <= 8'd0;
            vy_q    <= 7'd0;
            vc_q    <= 3'd0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bc_q    <= bc_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
            plot_q  <= plot_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;
    assign vga_plot   = plot_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_draw_arbiter.sv
// Directed + randomized bench for draw_arbiter; expected bursts come from a screen-level model of the arbiter.
module tb_draw_arbiter;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [31:0] x_in = 32'd0;
    logic [27:0] y_in = 28'd0;
    logic [11:0] colour_in = 12'd0;
    logic [3:0]  grant, done;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, busy;

    draw_arbiter #(.SPRITE_W(W), .SPRITE_H(H)) dut (
        .clock(clock), .resetn(resetn), .req(req), .x_in(x_in), .y_in(y_in),
        .colour_in(colour_in), .grant(grant), .done(done), .vga_x(vga_x),
        .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int rr = 0;                 // model: where the next round-robin search starts
    int bx[4], by[4], bc[4];
    int last_w, plots;
    time t_grant, t_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic drive_inputs();
        x_in      = {8'(bx[3]), 8'(bx[2]), 8'(bx[1]), 8'(bx[0])};
        y_in      = {7'(by[3]), 7'(by[2]), 7'(by[1]), 7'(by[0])};
        colour_in = {3'(bc[3]), 3'(bc[2]), 3'(bc[1]), 3'(bc[0])};
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_plot"},  32'(vga_plot), 0);
        chk({tag, "_x"},     32'(vga_x), 0);
        chk({tag, "_y"},     32'(vga_y), 0);
        chk({tag, "_col"},   32'(vga_colour), 0);
    endtask

    // Called at a negedge with the DUT idle. Runs one whole request and checks every cycle.
    task automatic run_burst(input logic [3:0] reqv, input bit hold,
                             input int drop_at, input int chg_at, input int rst_at);
        int w, x0, y0, c0, sx, sy;
        bit exp_plot;
        w = -1;
        for (int k = 3; k >= 0; k--) if (reqv[(rr + k) % 4]) w = (rr + k) % 4;
        req = reqv;
        drive_inputs();
        if (w < 0) begin
            @(negedge clock);
            chk("idle_stay_busy", 32'(busy), 0);
            chk("idle_stay_grant", 32'(grant), 0);
            return;
        end
        x0 = bx[w]; y0 = by[w]; c0 = bc[w];
        rr = (w + 1) % 4;
        last_w = w;
        plots = 0;
        @(negedge clock);
        t_prev  = t_grant;
        t_grant = $time;
        chk("grant", 32'(grant), 32'(1 << w));
        chk("busy_draw", 32'(busy), 1);
        for (int p = 0; p < N; p++) begin
            sx = x0 + p % W;
            sy = y0 + p / W;
`ifdef DRAW_ARBITER_CLIP_EN
            exp_plot = (sx <= 159) && (sy <= 119);
`else
            exp_plot = 1'b1;
`endif
            chk("plot", 32'(vga_plot), 32'(exp_plot));
            chk("grant_hold", 32'(grant), 32'(1 << w));
            chk("done_low", 32'(done), 0);
            if (exp_plot) begin
                chk("vga_x", 32'(vga_x), 32'(sx % 256));
                chk("vga_y", 32'(vga_y), 32'(sy % 128));
                chk("vga_col", 32'(vga_colour), 32'(c0));
            end
            if (vga_plot === 1'b1) plots++;
            if (p == drop_at) req = 4'd0;
            if (p == chg_at) begin
                for (int i = 0; i < 4; i++) begin
                    bx[i] = $urandom_range(0, 159);
                    by[i] = $urandom_range(0, 119);
                    bc[i] = $urandom_range(0, 7);
                end
                drive_inputs();
            end
            if (p == rst_at) begin
                resetn = 1'b0;
                #1;
                chk_reset_outputs("async_rst");
                rr = 0;
                req = 4'd0;
                @(negedge clock);
                chk("rst_no_done", 32'(done), 0);
                resetn = 1'b1;
                return;
            end
            @(negedge clock);
        end
        chk("done_pulse", 32'(done), 32'(1 << w));
        chk("done_grant0", 32'(grant), 0);
        chk("done_plot0", 32'(vga_plot), 0);
        chk("done_busy", 32'(busy), 1);
        if (!hold) req = 4'd0;
        @(negedge clock);
        chk("idle_done0", 32'(done), 0);
        chk("idle_busy0", 32'(busy), 0);
        chk("idle_plot0", 32'(vga_plot), 0);
    endtask

    initial begin
        int exp_order[5];
        int exp_plots;
        bit hold;
        int drop_at, chg_at;
        logic [3:0] rq;
        exp_order = '{0, 1, 2, 3, 0};
        t_grant = 0;
        for (int i = 0; i < 4; i++) begin bx[i] = 0; by[i] = 0; bc[i] = 0; end

        // Reset state
        repeat (2) @(negedge clock);
        chk_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clock);
        chk_reset_outputs("post_reset");

        // Single request on requester 0
        bx[0] = 10; by[0] = 20; bc[0] = 4;
        run_burst(4'b0001, 1'b0, -1, -1, -1);
        chk("single_plots", 32'(plots), 16);
        run_burst(4'b0000, 1'b0, -1, -1, -1);

        // All four held after a fresh reset: grant order 0,1,2,3,0 every 18 cycles
        resetn = 1'b0; #1; rr = 0;
        @(negedge clock); resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bx[i] = 20 * i + 5; by[i] = 10 * i + 3; bc[i] = i + 1;
        end
        for (int k = 0; k < 5; k++) begin
            run_burst(4'b1111, 1'b1, -1, -1, -1);
            chk("rr_order", 32'(last_w), 32'(exp_order[k]));
            if (k > 0) chk("rr_spacing", 32'(t_grant - t_prev), 180);
        end
        req = 4'd0;
        @(negedge clock);

        // Requester 0 keeps asking while 1 is also pending: 1 must come next
        run_burst(4'b0011, 1'b1, -1, -1, -1);
        run_burst(4'b0011, 1'b0, -1, -1, -1);
        chk("no_starve", 32'(last_w), 0);

        // Mid-burst drop on requester 2
        run_burst(4'b0100, 1'b0, 5, -1, -1);
        chk("drop_plots", 32'(plots), 16);

        // Input change mid-burst uses latched base
        run_burst(4'b1000, 1'b0, -1, 3, -1);

        // Screen-edge burst: clipped or wrapped depending on build
        bx[1] = 158; by[1] = 118; bc[1] = 6;
        run_burst(4'b0010, 1'b0, -1, -1, -1);
`ifdef DRAW_ARBITER_CLIP_EN
        exp_plots = 4;
`else
        exp_plots = 16;
`endif
        chk("edge_plots", 32'(plots), 32'(exp_plots));
        bx[2] = 254; by[2] = 126; bc[2] = 5;
        run_burst(4'b0100, 1'b0, -1, -1, -1);

        // Async reset at plot 7, then requester 1 wins from a reset pointer
        bx[3] = 40; by[3] = 50; bc[3] = 2;
        run_burst(4'b1000, 1'b0, -1, -1, 7);
        chk("rst_idle_busy", 32'(busy), 0);
        bx[1] = 70; by[1] = 60; bc[1] = 3;
        run_burst(4'b0010, 1'b0, -1, -1, -1);
        chk("post_rst_grant", 32'(last_w), 1);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                bx[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 159);
                by[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 119);
                bc[i] = $urandom_range(0, 7);
            end
            rq      = 4'($urandom_range(1, 15));
            hold    = 1'($urandom_range(0, 1));
            drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1;
            chg_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1;
            if (drop_at >= 0) hold = 1'b0;
            run_burst(rq, hold, drop_at, chg_at, -1);
        end
        req = 4'd0;
        @(negedge clock);
        chk("final_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
